// File: rtl/timer_sched_pkg.sv
// Shared types and constants for timer_alarm_scheduler: FSM states, timer
// register map, control words and the bus-cycle record driven to the timer.
package timer_sched_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_CHECK    = 4'd1,
        S_WR_STOP  = 4'd2,
        S_WR_PL    = 4'd3,
        S_WR_PH    = 4'd4,
        S_WR_CLR   = 4'd5,
        S_WR_START = 4'd6,
        S_WAIT_IRQ = 4'd7,
        S_FIN_CLR  = 4'd8,
        S_FIN_STOP = 4'd9,
        S_DONE     = 4'd10
    } sched_state_t;

    localparam logic [2:0] TMR_STATUS   = 3'd0;
    localparam logic [2:0] TMR_CONTROL  = 3'd1;
    localparam logic [2:0] TMR_PERIOD_L = 3'd2;
    localparam logic [2:0] TMR_PERIOD_H = 3'd3;

    localparam logic [15:0] CTRL_STOP      = 16'h0008;
    localparam logic [15:0] CTRL_START_ITO = 16'h0005;
    localparam logic [15:0] STATUS_CLEAR   = 16'h0000;

    // Delays below this complete without touching the timer.
    localparam logic [31:0] MIN_TIMED_DELAY = 32'd2;

    typedef struct packed {
        logic        cs;
        logic        write_n;
        logic [2:0]  addr;
        logic [15:0] data;
    } tmr_bus_t;

    localparam tmr_bus_t BUS_IDLE = '{cs: 1'b0, write_n: 1'b1, addr: 3'd0, data: 16'd0};

    function automatic tmr_bus_t bus_write(input logic [2:0] addr, input logic [15:0] data);
        tmr_bus_t b;
        b.cs      = 1'b1;
        b.write_n = 1'b0;
        b.addr    = addr;
        b.data    = data;
        return b;
    endfunction

endpackage

// File: rtl/timer_alarm_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after a rotating
// pointer; the pointer moves past the winner when the grant is taken.
module rr_arbiter #(
    parameter int N_CH = 4,
    parameter int CH_W = $clog2(N_CH)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [N_CH-1:0] i_req,
    input  logic            i_advance,
    output logic            o_valid,
    output logic [N_CH-1:0] o_grant,
    output logic [CH_W-1:0] o_grant_idx
);

    localparam int              SW     = CH_W + 1;
    localparam logic [SW-1:0]   N_CH_V = SW'(N_CH);
    localparam logic [CH_W-1:0] LAST   = CH_W'(N_CH - 1);

    logic [CH_W-1:0] r_ptr;
    logic [SW-1:0]   w_sum;
    logic            w_valid;
    logic [CH_W-1:0] w_idx;

    always_comb begin
        w_valid = 1'b0;
        w_idx   = '0;
        w_sum   = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_sum = {1'b0, r_ptr} + SW'(k);
            if (w_sum >= N_CH_V) begin
                w_sum = w_sum - N_CH_V;
            end
            if (!w_valid && i_req[w_sum[CH_W-1:0]]) begin
                w_valid = 1'b1;
                w_idx   = w_sum[CH_W-1:0];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_advance && w_valid) begin
            r_ptr <= (w_idx == LAST) ? '0 : w_idx + CH_W'(1);
        end
    end

    assign o_valid     = w_valid;
    assign o_grant_idx = w_idx;
    assign o_grant     = w_valid ? (N_CH'(1) << w_idx) : '0;

endmodule

// File: rtl/timer_alarm_scheduler.sv
// Shares one Avalon-MM interval timer between N_CH one-shot delay requesters.
// Optional cancel support: define TIMER_ALARM_SCHEDULER_CANCEL_EN.
module timer_alarm_scheduler
    import timer_sched_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CH_W = $clog2(N_CH)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_CH-1:0]    req,
    input  logic [N_CH*32-1:0] req_delay,
    output logic [N_CH-1:0]    done,
    output logic               busy,
    output logic [CH_W-1:0]    active_ch,
    output logic [2:0]         tmr_address,
    output logic               tmr_chipselect,
    output logic               tmr_write_n,
    output logic [15:0]        tmr_writedata,
    input  logic [15:0]        tmr_readdata,
    input  logic               tmr_irq,
`ifdef TIMER_ALARM_SCHEDULER_CANCEL_EN
    input  logic [N_CH-1:0]    cancel,
    output logic [N_CH-1:0]    cancelled,
`endif
    output sched_state_t       o_dbg_state
);

    // Handshake: req is a level held by the channel; the grant is taken in
    // IDLE, and exactly one done (or cancelled) pulse closes it. There is no
    // back-pressure on the timer port, so every bus write completes in one cycle.

    sched_state_t    r_state;
    sched_state_t    w_next_state;
    logic [31:0]     r_delay;
    logic [CH_W-1:0] r_active_ch;
    logic [N_CH-1:0] r_active_oh;
    logic [31:0]     w_period;
    tmr_bus_t        w_bus;
    logic            w_arb_valid;
    logic [N_CH-1:0] w_arb_grant;
    logic [CH_W-1:0] w_arb_idx;
    logic            w_take_grant;
    logic            w_cancel_end;
    logic            w_unused_rd;

    rr_arbiter #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_arb (
        .i_clk       (clk),
        .i_rst_n     (reset_n),
        .i_req       (req),
        .i_advance   (w_take_grant),
        .o_valid     (w_arb_valid),
        .o_grant     (w_arb_grant),
        .o_grant_idx (w_arb_idx)
    );

    assign w_take_grant = (r_state == S_IDLE) && w_arb_valid;
    assign w_period     = r_delay - 32'd1;
    assign w_unused_rd  = ^tmr_readdata;

`ifdef TIMER_ALARM_SCHEDULER_CANCEL_EN
    logic r_cancel_pend;
    logic w_cancel_hit;
    logic w_cancel_go;

    assign w_cancel_hit = |(cancel & r_active_oh);
    assign w_cancel_end = r_cancel_pend;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cancel_pend <= 1'b0;
        end else if (w_take_grant) begin
            r_cancel_pend <= 1'b0;
        end else if (w_cancel_go) begin
            r_cancel_pend <= 1'b1;
        end
    end
`else
    assign w_cancel_end = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_delay     <= '0;
            r_active_ch <= '0;
            r_active_oh <= '0;
        end else if (w_take_grant) begin
            r_delay     <= req_delay[{w_arb_idx, 5'd0} +: 32];
            r_active_ch <= w_arb_idx;
            r_active_oh <= w_arb_grant;
        end
    end

    // Bus outputs are decoded from the state register, one write per state.
    always_comb begin
        w_next_state = r_state;
        w_bus        = BUS_IDLE;
`ifdef TIMER_ALARM_SCHEDULER_CANCEL_EN
        w_cancel_go  = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_arb_valid) w_next_state = S_CHECK;
            end
            S_CHECK: begin
                w_next_state = (r_delay < MIN_TIMED_DELAY) ? S_DONE : S_WR_STOP;
            end
            S_WR_STOP: begin
                w_bus        = bus_write(TMR_CONTROL, CTRL_STOP);
                w_next_state = S_WR_PL;
            end
            S_WR_PL: begin
                w_bus        = bus_write(TMR_PERIOD_L, w_period[15:0]);
                w_next_state = S_WR_PH;
            end
            S_WR_PH: begin
                w_bus        = bus_write(TMR_PERIOD_H, w_period[31:16]);
                w_next_state = S_WR_CLR;
            end
            S_WR_CLR: begin
                w_bus        = bus_write(TMR_STATUS, STATUS_CLEAR);
                w_next_state = S_WR_START;
            end
            S_WR_START: begin
                w_bus        = bus_write(TMR_CONTROL, CTRL_START_ITO);
                w_next_state = S_WAIT_IRQ;
            end
            S_WAIT_IRQ: begin
                if (tmr_irq) w_next_state = S_FIN_CLR;
            end
            S_FIN_CLR: begin
                w_bus        = bus_write(TMR_STATUS, STATUS_CLEAR);
                w_next_state = S_FIN_STOP;
            end
            S_FIN_STOP: begin
                w_bus        = bus_write(TMR_CONTROL, CTRL_STOP);
                w_next_state = S_DONE;
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
`ifdef TIMER_ALARM_SCHEDULER_CANCEL_EN
        // A cancel during programming or waiting still leaves the timer cleared and stopped.
        if (w_cancel_hit && (r_state == S_WR_STOP || r_state == S_WR_PL ||
                             r_state == S_WR_PH || r_state == S_WR_CLR ||
                             r_state == S_WR_START || r_state == S_WAIT_IRQ)) begin
            w_next_state = S_FIN_CLR;
            w_cancel_go  = 1'b1;
        end
`endif
    end

    always_comb begin
        done = '0;
        if (r_state == S_DONE && !w_cancel_end) begin
            done = r_active_oh;
        end
    end

`ifdef TIMER_ALARM_SCHEDULER_CANCEL_EN
    always_comb begin
        cancelled = '0;
        if (r_state == S_DONE && w_cancel_end) begin
            cancelled = r_active_oh;
        end
    end
`endif

    assign busy           = (r_state != S_IDLE) && (r_state != S_DONE);
    assign active_ch      = r_active_ch;
    assign tmr_chipselect = w_bus.cs;
    assign tmr_write_n    = w_bus.write_n;
    assign tmr_address    = w_bus.addr;
    assign tmr_writedata  = w_bus.data;
    assign o_dbg_state    = r_state;

endmodule
